// File: rtl/alu_addsub_pipe.sv
// Pipelined add/subtract unit: the carry chain is cut into SEG-bit
// segments, one per stage, with valid/ready handshakes and full backpressure.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   in_valid/in_ready    - operand handshake: a, b, op, ci
//   out_valid/out_ready  - result handshake: result, co, zero, neg, ovf
`timescale 1ns/1ps
module alu_addsub_pipe #(
  parameter int N   = 8,
  parameter int SEG = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  input  logic         ci,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         co,
  output logic         zero,
  output logic         neg,
  output logic         ovf
);

  localparam int STAGES = N / SEG;
  localparam int L = STAGES - 1;

  // Per-stage registers: operands travel with the beat so that
  // later stages can resolve their own segment.
  logic [N-1:0] a_q   [STAGES];
  logic [N-1:0] bp_q  [STAGES];
  logic [N-1:0] res_q [STAGES];
  logic         c_q   [STAGES];
  logic         sub_q [STAGES];
  logic         v_q   [STAGES];

  logic [STAGES-1:0] adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [N-1:0] src_a;
    logic [N-1:0] src_bp;
    logic [N-1:0] src_res;
    logic         src_c;
    logic         src_sub;
    logic         src_v;
    logic [SEG:0] sum;
    logic [N-1:0] nres;

    if (k == 0) begin : g_in
      // op[0] selects subtract; op[1] selects the external carry/borrow.
      assign src_a   = a;
      assign src_bp  = op[0] ? ~b : b;
      assign src_c   = op[1] ? (ci ^ op[0]) : op[0];
      assign src_sub = op[0];
      assign src_v   = in_valid;
      assign src_res = '0;
    end else begin : g_chain
      assign src_a   = a_q[k-1];
      assign src_bp  = bp_q[k-1];
      assign src_c   = c_q[k-1];
      assign src_sub = sub_q[k-1];
      assign src_v   = v_q[k-1];
      assign src_res = res_q[k-1];
    end

    assign sum = {1'b0, src_a[k*SEG +: SEG]}
               + {1'b0, src_bp[k*SEG +: SEG]}
               + {{SEG{1'b0}}, src_c};

    always_comb begin
      nres = src_res;
      nres[k*SEG +: SEG] = sum[SEG-1:0];
    end

    // A stage moves when it is empty or its successor moves,
    // which lets bubbles collapse.
    if (k == L) begin : g_last
      assign adv[k] = !v_q[k] || out_ready;
    end else begin : g_mid
      assign adv[k] = !v_q[k] || adv[k+1];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        v_q[k]   <= 1'b0;
        a_q[k]   <= '0;
        bp_q[k]  <= '0;
        res_q[k] <= '0;
        c_q[k]   <= 1'b0;
        sub_q[k] <= 1'b0;
      end else if (adv[k]) begin
        v_q[k]   <= src_v;
        a_q[k]   <= src_a;
        bp_q[k]  <= src_bp;
        res_q[k] <= nres;
        c_q[k]   <= sum[SEG];
        sub_q[k] <= src_sub;
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v_q[L];

  // Outputs are forced to zero while no beat is presented so that
  // stale bubble contents never leak out.
  assign result = out_valid ? res_q[L] : '0;
  assign co     = out_valid & (c_q[L] ^ sub_q[L]);
  assign zero   = out_valid & (res_q[L] == '0);
  assign neg    = out_valid & res_q[L][N-1];
  assign ovf    = out_valid
                & (a_q[L][N-1] == bp_q[L][N-1])
                & (res_q[L][N-1] != a_q[L][N-1]);

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// Self-checking bench for alu_addsub_pipe: 8/4 and 32/8 instances
// checked against an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_addsub_pipe;

  typedef struct packed {
    logic [31:0] res;
    logic        co;
    logic        zero;
    logic        neg;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic       i8_valid = 0, i8_ready, o8_valid, o8_ready = 1;
  logic [7:0] a8 = 0, b8 = 0, r8;
  logic [1:0] op8 = 0;
  logic       ci8 = 0, co8, z8, n8, v8;

  logic        i32_valid = 0, i32_ready, o32_valid, o32_ready = 1;
  logic [31:0] a32 = 0, b32 = 0, r32;
  logic [1:0]  op32 = 0;
  logic        ci32 = 0, co32, z32, n32, v32;

  alu_addsub_pipe #(.N(8), .SEG(4)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(i8_valid), .in_ready(i8_ready),
    .a(a8), .b(b8), .op(op8), .ci(ci8),
    .out_valid(o8_valid), .out_ready(o8_ready),
    .result(r8), .co(co8), .zero(z8), .neg(n8), .ovf(v8)
  );

  alu_addsub_pipe #(.N(32), .SEG(8)) dut32 (
    .clk(clk), .reset(reset),
    .in_valid(i32_valid), .in_ready(i32_ready),
    .a(a32), .b(b32), .op(op32), .ci(ci32),
    .out_valid(o32_valid), .out_ready(o32_ready),
    .result(r32), .co(co32), .zero(z32), .neg(n32), .ovf(v32)
  );

  // Reference: plain integer add/subtract of width w.
  function automatic exp_t model(input int w, input logic [31:0] ta,
                                 input logic [31:0] tb, input logic [1:0] top,
                                 input logic tci);
    exp_t e;
    longint mask, ua, ub, sa, sb, c, full, sres, lim;
    mask = (longint'(1) <<< w) - 1;
    ua = longint'(ta) & mask;
    ub = longint'(tb) & mask;
    sa = ua[w-1] ? ua - (longint'(1) <<< w) : ua;
    sb = ub[w-1] ? ub - (longint'(1) <<< w) : ub;
    c = top[1] ? longint'(tci) : 0;
    lim = longint'(1) <<< (w - 1);
    if (!top[0]) begin
      full = ua + ub + c;
      sres = sa + sb + c;
      e.co = ((full >>> w) & 1) != 0;
    end else begin
      full = ua - ub - c;
      sres = sa - sb - c;
      e.co = ua < (ub + c);
    end
    e.res  = 32'(full & mask);
    e.zero = (e.res == 0);
    e.neg  = e.res[w-1];
    e.ovf  = (sres > lim - 1) || (sres < -lim);
    return e;
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    i8_valid = 0; i32_valid = 0;
    o8_ready = 1; o32_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if ({o8_valid, r8, co8, z8, n8, v8} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset8_outputs got v=%b r=%h flags=%b%b%b%b want all 0",
               o8_valid, r8, co8, z8, n8, v8);
    end
    n_checks++;
    if ({o32_valid, r32, co32, z32, n32, v32} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset32_outputs got v=%b r=%h flags=%b%b%b%b want all 0",
               o32_valid, r32, co32, z32, n32, v32);
    end
    n_checks++;
    if ({i8_ready, i32_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_in_ready got %b%b want 11", i8_ready, i32_ready);
    end
  endtask

  task automatic directed8(input string nm, input logic [7:0] ta,
                           input logic [7:0] tb, input logic [1:0] top,
                           input logic tci, input logic [7:0] er,
                           input logic eco, input logic ez,
                           input logic en, input logic ev);
    int lat;
    @(negedge clk);
    a8 = ta; b8 = tb; op8 = top; ci8 = tci;
    i8_valid = 1; o8_ready = 1;
    #1;
    n_checks++;
    if (i8_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_accept in_ready=%b want 1", nm, i8_ready);
    end
    @(negedge clk);
    i8_valid = 0;
    a8 = 8'($urandom); b8 = 8'($urandom); op8 = 2'($urandom); ci8 = 1'($urandom);
    lat = 1;
    while (o8_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL %s_latency got %0d want 2", nm, lat);
    end
    n_checks++;
    if ({r8, co8, z8, n8, v8} !== {er, eco, ez, en, ev}) begin
      n_fail++;
      $display("FAIL %s got r=%h co=%b z=%b n=%b v=%b want r=%h co=%b z=%b n=%b v=%b",
               nm, r8, co8, z8, n8, v8, er, eco, ez, en, ev);
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    directed8("add_7f_01",  8'h7F, 8'h01, 2'b00, 1'b1, 8'h80, 0, 0, 1, 1);
    directed8("sub_05_07",  8'h05, 8'h07, 2'b01, 1'b1, 8'hFE, 1, 0, 1, 0);
    directed8("sub_80_01",  8'h80, 8'h01, 2'b01, 1'b0, 8'h7F, 0, 0, 0, 1);
    directed8("addc_ff_00", 8'hFF, 8'h00, 2'b10, 1'b1, 8'h00, 1, 1, 0, 0);
    directed8("subb_00_00", 8'h00, 8'h00, 2'b11, 1'b1, 8'hFF, 1, 0, 1, 0);
  endtask

  task automatic test_backpressure();
    exp_t q[$];
    exp_t e;
    logic [7:0] ta [6], tb [6];
    logic [1:0] top [6];
    logic tci [6];
    int sent = 0, got = 0;
    logic stall_prev = 0;
    logic [12:0] saved = '0;
    bit saw_block = 0, saw_accept = 0;
    for (int i = 0; i < 6; i++) begin
      ta[i] = 8'($urandom); tb[i] = 8'($urandom);
      top[i] = 2'(i % 4); tci[i] = 1'($urandom);
    end
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      o8_ready = !(cyc >= 2 && cyc <= 5);
      i8_valid = (sent < 6);
      if (sent < 6) begin
        a8 = ta[sent]; b8 = tb[sent]; op8 = top[sent]; ci8 = tci[sent];
      end
      #1;
      if (stall_prev) begin
        n_checks++;
        if ({o8_valid, r8, co8, z8, n8, v8} !== saved) begin
          n_fail++;
          $display("FAIL bp_stable cyc %0d got %h want %h", cyc,
                   {o8_valid, r8, co8, z8, n8, v8}, saved);
        end
      end
      if (q.size() == 2) begin
        n_checks++;
        if (i8_ready !== o8_ready) begin
          n_fail++;
          $display("FAIL bp_in_ready_full cyc %0d got %b want %b",
                   cyc, i8_ready, o8_ready);
        end
        if (!o8_ready) saw_block = 1;
        else if (i8_valid && i8_ready) saw_accept = 1;
      end
      if (o8_valid && o8_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_unexpected_beat cyc %0d r=%h", cyc, r8);
        end else begin
          e = q.pop_front();
          if ({24'd0, r8, co8, z8, n8, v8} !== e) begin
            n_fail++;
            $display("FAIL bp_beat%0d got r=%h co=%b z=%b n=%b v=%b want r=%h co=%b z=%b n=%b v=%b",
                     got, r8, co8, z8, n8, v8, e.res[7:0], e.co, e.zero, e.neg, e.ovf);
          end
        end
        got++;
      end
      if (i8_valid && i8_ready) begin
        q.push_back(model(8, {24'd0, a8}, {24'd0, b8}, op8, ci8));
        sent++;
      end
      stall_prev = o8_valid && !o8_ready;
      saved = {o8_valid, r8, co8, z8, n8, v8};
    end
    i8_valid = 0; o8_ready = 1;
    n_checks++;
    if (sent !== 6 || got !== 6 || q.size() !== 0) begin
      n_fail++;
      $display("FAIL bp_count sent=%0d got=%0d left=%0d want 6/6/0",
               sent, got, q.size());
    end
    n_checks++;
    if (!saw_block || !saw_accept) begin
      n_fail++;
      $display("FAIL bp_full_behaviour block=%0d accept=%0d want 1/1",
               saw_block, saw_accept);
    end
  endtask

  task automatic test_reset_midflight();
    bit stale = 0;
    @(negedge clk);
    o8_ready = 0;
    i8_valid = 1; a8 = 8'h12; b8 = 8'h34; op8 = 2'b00; ci8 = 0;
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h11; op8 = 2'b01;
    @(negedge clk);
    i8_valid = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    n_checks++;
    if ({o8_valid, r8, co8, z8, n8, v8} !== 13'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs got v=%b r=%h flags=%b%b%b%b want all 0",
               o8_valid, r8, co8, z8, n8, v8);
    end
    n_checks++;
    if (i8_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_in_ready got %b want 1", i8_ready);
    end
    o8_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (o8_valid !== 1'b0) stale = 1;
    end
    n_checks++;
    if (stale) begin
      n_fail++;
      $display("FAIL midreset_stale_beat got out_valid=1 want 0");
    end
  endtask

  task automatic test_random32();
    exp_t q[$];
    exp_t e;
    logic [31:0] fa [4], fb [4];
    logic [1:0] fop [4];
    logic fci [4];
    int accepted = 0, cycles = 0, popped = 0;
    logic stall_prev = 0;
    logic [36:0] saved = '0;
    fa[0] = 32'h8000_0000; fb[0] = 32'h1; fop[0] = 2'b01; fci[0] = 0;
    fa[1] = 32'hFFFF_FFFF; fb[1] = 32'h1; fop[1] = 2'b00; fci[1] = 0;
    fa[2] = 32'h8000_0000; fb[2] = 32'h0; fop[2] = 2'b11; fci[2] = 1;
    fa[3] = 32'hFFFF_FFFF; fb[3] = 32'h0; fop[3] = 2'b10; fci[3] = 1;
    while ((accepted < 10000 || q.size() > 0) && cycles < 60000) begin
      @(negedge clk);
      cycles++;
      if (accepted < 4) begin
        i32_valid = 1;
        a32 = fa[accepted]; b32 = fb[accepted];
        op32 = fop[accepted]; ci32 = fci[accepted];
      end else if (accepted < 10000) begin
        i32_valid = ($urandom_range(3) != 0);
        a32 = pick32(); b32 = pick32();
        op32 = 2'($urandom); ci32 = 1'($urandom);
      end else begin
        i32_valid = 0;
      end
      o32_ready = ($urandom_range(3) != 0);
      #1;
      if (stall_prev) begin
        n_checks++;
        if ({o32_valid, r32, co32, z32, n32, v32} !== saved) begin
          n_fail++;
          $display("FAIL rand_stable cyc %0d got %h want %h", cycles,
                   {o32_valid, r32, co32, z32, n32, v32}, saved);
        end
      end
      if (o32_valid && o32_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_unexpected_beat cyc %0d r=%h", cycles, r32);
        end else begin
          e = q.pop_front();
          if ({r32, co32, z32, n32, v32} !== e) begin
            n_fail++;
            $display("FAIL rand_beat%0d got r=%h co=%b z=%b n=%b v=%b want r=%h co=%b z=%b n=%b v=%b",
                     popped, r32, co32, z32, n32, v32,
                     e.res, e.co, e.zero, e.neg, e.ovf);
          end
        end
        popped++;
      end
      if (i32_valid && i32_ready) begin
        q.push_back(model(32, a32, b32, op32, ci32));
        accepted++;
      end
      stall_prev = o32_valid && !o32_ready;
      saved = {o32_valid, r32, co32, z32, n32, v32};
    end
    i32_valid = 0; o32_ready = 1;
    n_checks++;
    if (accepted !== 10000 || q.size() !== 0) begin
      n_fail++;
      $display("FAIL rand_budget accepted=%0d pending=%0d want 10000/0",
               accepted, q.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_random32();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
